// File: rtl/pldata_pkg.sv
// pldata_pkg: definitions shared by the pldata capture engine.
//   state_t      - capture FSM states (IDLE, CAPTURE, DONE)
//   LANES        - samples per RAM word for the default 16-bit-sample/32-bit-word build
//   lanes_of     - samples per word for an arbitrary width pair
//   bank_base    - byte offset of bank 1 (bank 0 sits at 0)
//   byte_stride  - byte distance between consecutive RAM words
package pldata_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_WORD_W = 32;
  localparam int LANES      = DEF_WORD_W / DEF_DATA_W;

  function automatic int lanes_of(input int word_w, input int data_w);
    return word_w / data_w;
  endfunction

  function automatic int bank_base(input int addr_w);
    return 1 << (addr_w - 1);
  endfunction

  function automatic int byte_stride(input int word_w);
    return word_w / 8;
  endfunction

endpackage

// File: rtl/pldata_pattern_gen.sv
// pldata_pattern_gen: free-running ramp used as a built-in test source.
// Only instantiated when PLDATA_CAPTURE_TEST_PATTERN_EN is defined.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - restart the ramp at 0 (accepted start of a frame)
//   enable    - ramp advances and presents a valid sample each enabled cycle
//   data      - current ramp value, wraps modulo 2^DATA_W
//   valid     - sample strobe (equal to enable)
module pldata_pattern_gen
  import pldata_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  logic [DATA_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign data  = count_reg;
  assign valid = enable;

endmodule

// File: rtl/pldata_capture.sv
// pldata_capture: selects one sample stream, packs DATA_W-bit samples into
// WORD_W-bit words and writes one frame into alternating halves (banks) of
// the PS-visible pldata RAM, pulsing done_o when a frame completes.
// Optional feature: PLDATA_CAPTURE_TEST_PATTERN_EN adds an internal ramp
// source selected by src_sel_in == NUM_SRC.
// Ports:
//   clk, rst                  - ADC sample clock, synchronous active-high reset
//   src_data_in/src_valid_in  - NUM_SRC packed sample streams and strobes
//   src_sel_in, frame_len_in  - source and frame length, latched on start
//   start_in, abort_in        - arm one frame / cancel the current frame
//   ram_wr_o/addr_o/data_o    - registered RAM write port (byte address)
//   busy_o, done_o            - frame in progress / frame complete pulse
//   bank_o, frame_cnt_o       - next bank to fill / completed frame count
//   overflow_o                - sticky flag: sample lost while in DONE
module pldata_capture
  import pldata_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 16,
  parameter int WORD_W  = 32,
  parameter int ADDR_W  = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC*DATA_W-1:0]    src_data_in,
  input  logic [NUM_SRC-1:0]           src_valid_in,
  input  logic [$clog2(NUM_SRC+1)-1:0] src_sel_in,
  input  logic [ADDR_W-3:0]            frame_len_in,
  input  logic                         start_in,
  input  logic                         abort_in,
  output logic                         ram_wr_o,
  output logic [ADDR_W-1:0]            ram_addr_o,
  output logic [WORD_W-1:0]            ram_data_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         bank_o,
  output logic [15:0]                  frame_cnt_o,
  output logic                         overflow_o
);

  localparam int NL     = lanes_of(WORD_W, DATA_W);
  localparam int LANE_W = (NL > 1) ? $clog2(NL) : 1;
  localparam int SEL_W  = $clog2(NUM_SRC + 1);
  localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int LEN_W  = ADDR_W - 2;
  localparam int STRIDE = byte_stride(WORD_W);

  localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(1 << (ADDR_W - 3));
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NL - 1);
  localparam logic [ADDR_W-1:0] BANK1     = ADDR_W'(bank_base(ADDR_W));

  state_t              state_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [LEN_W-1:0]    len_reg;
  logic [LEN_W-1:0]    word_idx_reg;
  logic [LANE_W-1:0]   lane_reg;
  logic [WORD_W-1:0]   pack_reg;
  logic                wr_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [WORD_W-1:0]   data_reg;
  logic                done_reg;
  logic                bank_reg;
  logic [15:0]         frame_cnt_reg;
  logic                overflow_reg;

  // Unpack the flat stream bus into one sample per source.
  logic [DATA_W-1:0] src_word [NUM_SRC];
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_word[gi] = src_data_in[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic start_ok;
  assign start_ok = (state_reg == IDLE) && start_in && !abort_in;

  // Out-of-range selects fall back to stream 0 (the ramp, when built,
  // claims the NUM_SRC code separately below).
  logic [IDX_W-1:0] sel_idx;
  assign sel_idx = (src_sel_in < SEL_W'(NUM_SRC)) ? IDX_W'(src_sel_in) : '0;

  logic [LEN_W-1:0] len_clamped;
  assign len_clamped = ((frame_len_in == '0) || (frame_len_in > MAX_LEN)) ? MAX_LEN : frame_len_in;

  logic [DATA_W-1:0] sel_data;
  logic              sel_valid;

`ifdef PLDATA_CAPTURE_TEST_PATTERN_EN
  logic              ramp_reg;
  logic [DATA_W-1:0] ramp_data;
  logic              ramp_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      ramp_reg <= 1'b0;
    end else if (start_ok) begin
      ramp_reg <= (src_sel_in == SEL_W'(NUM_SRC));
    end
  end

  // The ramp keeps running through DONE so that a ramp frame always ends
  // with one dropped sample, which exercises the overflow flag.
  pldata_pattern_gen #(
    .DATA_W(DATA_W)
  ) u_pattern_gen (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_ok),
    .enable (state_reg != IDLE),
    .data   (ramp_data),
    .valid  (ramp_valid)
  );

  always_comb begin
    sel_data  = src_word[idx_reg];
    sel_valid = src_valid_in[idx_reg];
    if (ramp_reg) begin
      sel_data  = ramp_data;
      sel_valid = ramp_valid;
    end
  end
`else
  always_comb begin
    sel_data  = src_word[idx_reg];
    sel_valid = src_valid_in[idx_reg];
  end
`endif

  // Word as it stands once the current sample is dropped into its lane.
  logic [WORD_W-1:0] word_next;
  always_comb begin
    word_next = pack_reg;
    word_next[lane_reg*DATA_W +: DATA_W] = sel_data;
  end

  // word_idx never exceeds MAX_LEN-1, so the offset stays inside the bank.
  logic [ADDR_W-1:0] addr_next;
  assign addr_next = (bank_reg ? BANK1 : '0) + ADDR_W'(32'(word_idx_reg) * STRIDE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      len_reg       <= '0;
      word_idx_reg  <= '0;
      lane_reg      <= '0;
      pack_reg      <= '0;
      wr_reg        <= 1'b0;
      addr_reg      <= '0;
      data_reg      <= '0;
      done_reg      <= 1'b0;
      bank_reg      <= 1'b0;
      frame_cnt_reg <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      wr_reg   <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            state_reg    <= CAPTURE;
            idx_reg      <= sel_idx;
            len_reg      <= len_clamped;
            word_idx_reg <= '0;
            lane_reg     <= '0;
            pack_reg     <= '0;
            overflow_reg <= 1'b0;
          end
        end
        CAPTURE: begin
          if (abort_in) begin
            // Partial word is dropped; written words stay in RAM.
            state_reg <= IDLE;
            lane_reg  <= '0;
          end else if (sel_valid) begin
            if (lane_reg == LAST_LANE) begin
              wr_reg       <= 1'b1;
              addr_reg     <= addr_next;
              data_reg     <= word_next;
              lane_reg     <= '0;
              word_idx_reg <= word_idx_reg + LEN_W'(1);
              if (word_idx_reg + LEN_W'(1) == len_reg) begin
                state_reg <= DONE;
              end
            end else begin
              pack_reg <= word_next;
              lane_reg <= lane_reg + LANE_W'(1);
            end
          end
        end
        DONE: begin
          state_reg     <= IDLE;
          done_reg      <= 1'b1;
          bank_reg      <= ~bank_reg;
          frame_cnt_reg <= frame_cnt_reg + 16'd1;
          if (sel_valid) begin
            overflow_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ram_wr_o    = wr_reg;
  assign ram_addr_o  = addr_reg;
  assign ram_data_o  = data_reg;
  assign busy_o      = (state_reg != IDLE);
  assign done_o      = done_reg;
  assign bank_o      = bank_reg;
  assign frame_cnt_o = frame_cnt_reg;
  assign overflow_o  = overflow_reg;

endmodule

// File: doc/pldata_capture.md
# pldata_capture

Parametrised capture engine between the sample sources (AD9826 capture path, built-in test pattern) and the PS-visible pldata BRAM port. It selects one of `NUM_SRC` sample streams and packs `DATA_W`-bit samples into `WORD_W`-bit words. Each frame of `frame_len_in` words is written into one half of the RAM, with halves used alternately (ping-pong), and a per-frame done pulse is raised for the PS interrupt/GPIO.

## Interface
- `NUM_SRC`, 2: number of external sample streams.
- `DATA_W`, 16: sample width; `WORD_W` must be an integer multiple of it.
- `WORD_W`, 32: RAM word width.
- `ADDR_W`, 12: RAM byte-address width; each bank is 2^(ADDR_W-1) bytes.
- `clk` in 1: single clock, the ADC sample clock domain.
- `rst` in 1: synchronous, active-high reset.
- `src_data_in` in NUM_SRC*DATA_W: stream k occupies bits [k*DATA_W +: DATA_W].
- `src_valid_in` in NUM_SRC: per-stream sample strobe.
- `src_sel_in` in $clog2(NUM_SRC+1): source select; latched on start.
- `frame_len_in` in ADDR_W-2: frame length in words; latched on start.
- `start_in` in 1: single-cycle pulse that arms one frame.
- `abort_in` in 1: single-cycle pulse that cancels the current frame.
- `ram_wr_o` out 1: RAM write strobe.
- `ram_addr_o` out ADDR_W: RAM byte address.
- `ram_data_o` out WORD_W: RAM write data.
- `busy_o` out 1: high in CAPTURE and DONE.
- `done_o` out 1: one-cycle pulse at frame completion.
- `bank_o` out 1: bank that will receive the next frame.
- `frame_cnt_o` out 16: count of completed frames; wraps 0xFFFF to 0.
- `overflow_o` out 1: sticky lost-sample flag.

## Operation
- The FSM has three states: IDLE, CAPTURE and DONE.
- IDLE -> CAPTURE on `start_in` with no `abort_in` in the same cycle.
  - Latch `src_sel_in` and `frame_len_in`.
  - Clear the word, sample and lane counters.
  - Clear `overflow_o`.
- `start_in` while `busy_o` is high is ignored.
- Frame length:
  - Legal range is 1..2^(ADDR_W-3) words.
  - A value of 0 or above the range is clamped to 2^(ADDR_W-3).
- Source select:
  - A `src_sel_in` value >= NUM_SRC selects stream 0 (see Configuration for the exception).
- Packing:
  - Each valid sample from the selected stream shifts into the next lane, LSB lane first.
  - A word is complete after WORD_W/DATA_W samples.
  - Valids on unselected streams are ignored.
- Addressing:
  - `ram_addr_o` = bank_o * 2^(ADDR_W-1) + word_idx * (WORD_W/8).
  - The address never crosses into the other bank.
- CAPTURE -> DONE when word number `frame_len` has been written.
- DONE lasts exactly one cycle, then returns to IDLE. In that cycle:
  - `done_o` = 1.
  - `bank_o` toggles.
  - `frame_cnt_o` increments.
- A selected-source valid that arrives in DONE sets `overflow_o`; the sample is dropped.
- `abort_in` in CAPTURE:
  - Returns to IDLE next cycle.
  - Any partial word is discarded.
  - No `done_o`, no bank toggle, no count increment.
  - Words already written remain in RAM.
- `abort_in` in IDLE or DONE has no effect.

## Timing
- Reset values:
  - All outputs are 0.
  - FSM in IDLE; internal counters at 0.
- Write latency: `ram_wr_o`, `ram_addr_o` and `ram_data_o` assert in the cycle after the valid that completes a word.
- All three RAM outputs are registered. `ram_wr_o` is high for 1 cycle per word.
- `done_o` asserts in the cycle after the final `ram_wr_o`.
- Back-to-back samples (valid every cycle) are sustained with no stall.
- Minimum frame period is frame_len*(WORD_W/DATA_W) + 2 cycles, since a new `start_in` is accepted once back in IDLE.
- `rst` mid-frame:
  - Immediate return to reset values, including `bank_o` = 0 and `frame_cnt_o` = 0.
  - No write is issued in the reset cycle.

## Configuration
- `PLDATA_CAPTURE_TEST_PATTERN_EN` defined:
  - `src_sel_in` == NUM_SRC selects an internal ramp.
  - The ramp emits a DATA_W-bit count, valid every cycle while in CAPTURE.
  - It restarts at 0 on each accepted `start_in` and wraps modulo 2^DATA_W.
- Macro undefined:
  - No ramp logic is built.
  - `src_sel_in` == NUM_SRC maps to stream 0 like any other out-of-range value.

## Structure
- Shared package `pldata_pkg` holds:
  - The state enum (IDLE, CAPTURE, DONE).
  - `LANES` = WORD_W/DATA_W.
  - The bank-base and byte-stride constant functions.
- One sub-module, `pldata_pattern_gen` (ramp generator), instantiated only under the macro.

## Test plan
- Single frame from stream 0:
  - Stimulus: start, `frame_len_in`=4, 8 valid samples 0x0001..0x0008.
  - Required: writes 0x00020001, 0x00040003, 0x00060005, 0x00080007 at addresses 0x000, 0x004, 0x008, 0x00C.
  - Required: `done_o` one cycle after the last write; `bank_o`=1; `frame_cnt_o`=1.
- Second frame:
  - Required: writes start at address 0x800 (bank 1); `bank_o` returns to 0 afterwards.
- Abort after 3 samples:
  - Required: 1 write only; no `done_o`; `bank_o` and `frame_cnt_o` unchanged; a following frame starts at the same bank base.
- `frame_len_in`=0:
  - Required: 512 words written at 0x000..0x7FC, then `done_o`.
- Stream 1 selected, valids on both streams:
  - Required: only stream 1 data reaches RAM.
  - A `start_in` pulsed mid-frame is ignored.
- Macro on, `src_sel_in`=2, `frame_len_in`=2:
  - Required: writes 0x00010000 and 0x00030002; `overflow_o` set by the ramp valid that arrives in DONE.
- Macro off, same stimulus:
  - Required: stream 0 data is captured instead.
